// File: rtl/addsub_result_fifo.sv
// Result buffer behind the 4-bit adder/subtractor: derives {V,N,Z,C} for each
// result and queues sum+flags in a show-ahead FIFO with valid/ready on both sides.
module addsub_result_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [3:0]       sum,
  input  logic             carry,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sum,
  output logic [3:0]       out_flags,
  output logic [PTR_W:0]   level,
  output logic [7:0]       ovf_cnt
);

  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             flag_v;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic [7:0]       head;

  // Subtraction feeds ~B into the adder, so overflow needs A and B of opposite
  // sign, and the carry-out is the inverse of a borrow.
  always_comb begin
    flag_z = (sum == 4'b0000);
    flag_n = sum[3];
    flag_v = 1'b0;
    flag_c = 1'b0;
    if (mode) begin
      flag_v = (a_msb != b_msb) && (sum[3] != a_msb);
      flag_c = ~carry;
    end else begin
      flag_v = (a_msb == b_msb) && (sum[3] != a_msb);
      flag_c = carry;
    end
  end

  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ovf_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && flag_v && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  // Storage needs no reset; the empty case masks stale contents on the outputs.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sum, flag_v, flag_n, flag_z, flag_c};
  end

  assign head      = mem[rd_ptr];
  assign out_sum   = out_valid ? head[7:4] : 4'b0000;
  assign out_flags = out_valid ? head[3:0] : 4'b0000;

endmodule

// File: tb/tb_addsub_result_fifo.sv
// Directed bench for addsub_result_fifo: hand-computed flags, fill/full
// behaviour, pointer wrap, async reset and ovf_cnt saturation.
module tb_addsub_result_fifo;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [3:0] sum;
  logic       carry;
  logic       a_msb;
  logic       b_msb;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic [3:0] out_flags;
  logic [2:0] level;
  logic [7:0] ovf_cnt;

  int total;
  int bad;

  addsub_result_fifo #(.DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sum       (sum),
    .carry     (carry),
    .a_msb     (a_msb),
    .b_msb     (b_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .level     (level),
    .ovf_cnt   (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at a falling edge, return at the next falling edge.
  task automatic applyStimulus(input logic iv, input logic [3:0] s, input logic c,
                               input logic m, input logic a, input logic b,
                               input logic ordy);
    in_valid  = iv;
    sum       = iv ? s : 4'bxxxx;
    carry     = iv ? c : 1'bx;
    mode      = iv ? m : 1'bx;
    a_msb     = a;
    b_msb     = b;
    out_ready = ordy;
    @(negedge clk);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    sum       = 4'b0000;
    carry     = 1'b0;
    a_msb     = 1'b0;
    b_msb     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_in_ready",  16'(in_ready),  16'd1);
    checkOutput("rst_level",     16'(level),     16'd0);
    checkOutput("rst_ovf_cnt",   16'(ovf_cnt),   16'd0);
    checkOutput("rst_out_sum",   16'(out_sum),   16'd0);
    checkOutput("rst_out_flags", 16'(out_flags), 16'd0);

    // 1111 - 0010 = 1101, carry 1 -> no borrow
    applyStimulus(1, 4'b1101, 1, 1, 1, 0, 0);
    checkOutput("sub1_sum",   16'(out_sum),   16'b1101);
    checkOutput("sub1_flags", 16'(out_flags), 16'b0100);
    checkOutput("sub1_level", 16'(level),     16'd1);
    checkOutput("sub1_valid", 16'(out_valid), 16'd1);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1);
    checkOutput("pop1_level", 16'(level),   16'd0);
    checkOutput("pop1_sum",   16'(out_sum), 16'd0);
    checkOutput("pop1_ovf",   16'(ovf_cnt), 16'd0);

    // 0111 + 0010 = 1001 signed overflow
    applyStimulus(1, 4'b1001, 0, 0, 0, 0, 0);
    checkOutput("addovf_sum",   16'(out_sum),   16'b1001);
    checkOutput("addovf_flags", 16'(out_flags), 16'b1100);
    checkOutput("addovf_ovf",   16'(ovf_cnt),   16'd1);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1);

    // 1101 + 1010 = 0111 carry 1
    applyStimulus(1, 4'b0111, 1, 0, 1, 1, 0);
    checkOutput("add2_flags", 16'(out_flags), 16'b1001);
    checkOutput("add2_ovf",   16'(ovf_cnt),   16'd2);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1);

    // 1101 - 1010 = 0011 carry 1
    applyStimulus(1, 4'b0011, 1, 1, 1, 1, 0);
    checkOutput("sub2_flags", 16'(out_flags), 16'b0000);
    checkOutput("sub2_ovf",   16'(ovf_cnt),   16'd2);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1);

    // 1000 + 1000 = 0000 carry 1: zero with overflow
    applyStimulus(1, 4'b0000, 1, 0, 1, 1, 0);
    checkOutput("zero_flags", 16'(out_flags), 16'b1011);
    checkOutput("zero_ovf",   16'(ovf_cnt),   16'd3);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1);
    checkOutput("drain_level", 16'(level), 16'd0);

    // Fill with sums 1..4 starting from pointer 1, so the write pointer wraps
    for (int i = 1; i <= 4; i++) applyStimulus(1, 4'(i), 0, 0, 0, 0, 0);
    checkOutput("full_level",    16'(level),    16'd4);
    checkOutput("full_in_ready", 16'(in_ready), 16'd0);
    checkOutput("full_head",     16'(out_sum),  16'd1);
    applyStimulus(1, 4'd5, 0, 0, 0, 0, 0);
    checkOutput("ignored_level", 16'(level),   16'd4);
    checkOutput("ignored_head",  16'(out_sum), 16'd1);
    applyStimulus(1, 4'd5, 0, 0, 0, 0, 1);
    checkOutput("fullpop_level", 16'(level),    16'd3);
    checkOutput("fullpop_head",  16'(out_sum),  16'd2);
    checkOutput("fullpop_ready", 16'(in_ready), 16'd1);
    applyStimulus(1, 4'd5, 0, 0, 0, 0, 1);
    checkOutput("pushpop_level", 16'(level),   16'd3);
    checkOutput("pushpop_head",  16'(out_sum), 16'd3);
    for (int e = 3; e <= 5; e++) begin
      checkOutput($sformatf("order_%0d", e), 16'(out_sum), 16'(e));
      applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1);
    end
    checkOutput("order_empty", 16'(out_valid), 16'd0);

    applyStimulus(1, 4'd6, 0, 0, 0, 0, 0);
    applyStimulus(1, 4'd7, 0, 0, 0, 0, 0);
    applyStimulus(1, 4'd2, 0, 0, 0, 0, 0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 0);
    checkOutput("prereset_level", 16'(level), 16'd3);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", 16'(out_valid), 16'd0);
    checkOutput("areset_level", 16'(level),     16'd0);
    checkOutput("areset_ready", 16'(in_ready),  16'd1);
    checkOutput("areset_ovf",   16'(ovf_cnt),   16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1111 - 0011 = 1100 carry 1
    applyStimulus(1, 4'b1100, 1, 1, 1, 0, 0);
    checkOutput("post_sum",   16'(out_sum),   16'b1100);
    checkOutput("post_flags", 16'(out_flags), 16'b0100);
    checkOutput("post_level", 16'(level),     16'd1);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1);

    // 260 overflowing pushes streamed with the consumer always ready
    for (int k = 0; k < 260; k++) applyStimulus(1, 4'b1001, 0, 0, 0, 0, 1);
    checkOutput("sat_ovf",   16'(ovf_cnt),   16'd255);
    checkOutput("sat_level", 16'(level),     16'd1);
    checkOutput("sat_flags", 16'(out_flags), 16'b1100);
    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 1);
    checkOutput("sat_hold", 16'(ovf_cnt), 16'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_result_fifo.md
Name: addsub_result_fifo

Overview:
- Downstream stage of the 4-bit parallel adder/subtractor.
- Captures each sum/carry result together with the operation mode and the operand sign bits.
- Derives a flag vector {V,N,Z,C} for each result and buffers result+flags in a DEPTH-entry FIFO.
- Presents the FIFO to the consumer over a valid/ready handshake.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream result present on sum/carry/mode/a_msb/b_msb.
- in_ready  output  1  FIFO can accept; equals !full.
- mode  input  1  operation of this result: 0 = add, 1 = subtract (A-B).
- sum  input  4  adder/subtractor S output.
- carry  input  1  adder/subtractor carry-out.
- a_msb  input  1  bit 3 of operand A.
- b_msb  input  1  bit 3 of operand B, before inversion.
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  consumer accepts head entry.
- out_sum  output  4  sum of head entry.
- out_flags  output  4  {V,N,Z,C} of head entry.
- level  output  PTR_W+1  current occupancy, 0..DEPTH.
- ovf_cnt  output  8  saturating count of accepted entries with V=1.

Behaviour:
- Reset (async, rst_n=0):
  - Pointers, level and ovf_cnt clear to 0.
  - out_valid=0, in_ready=1.
  - out_sum and out_flags read 0 while empty; storage array contents are don't-care.
  - Reset asserted mid-transfer discards all entries; no partial entry survives.
- Push: when in_valid && in_ready at a rising edge, write {sum, flags} at wr_ptr and increment wr_ptr (modulo DEPTH).
- Pop: when out_valid && out_ready at a rising edge, increment rd_ptr (modulo DEPTH).
- Flags, computed combinationally from the inputs at the push edge and stored:
  - Z = (sum == 4'b0000).
  - N = sum[3].
  - V (add) = (a_msb == b_msb) && (sum[3] != a_msb).
  - V (sub) = (a_msb != b_msb) && (sum[3] != a_msb).
  - C (add) = carry.
  - C (sub) = ~carry, i.e. borrow; 1 means A<B unsigned.
- Output is show-ahead: out_sum/out_flags reflect mem[rd_ptr] combinationally from registered state. A new push becomes visible on out_* the cycle after the push edge (latency 1). No input-to-output combinational path.
- in_ready depends only on registered level (full when level==DEPTH), never on out_ready. When full, a simultaneous pop frees space, but the push is not accepted that cycle.
- Simultaneous push+pop while 0<level<DEPTH: both occur and level is unchanged.
- Simultaneous push+pop at level==0: only the push occurs, because out_valid=0.
- Push attempted while full (in_valid=1, in_ready=0): ignored, no state change; upstream must hold its data.
- Pointers wrap from DEPTH-1 to 0. level tracks occupancy exactly and distinguishes full from empty.
- ovf_cnt increments by 1 on each accepted push with V=1 and saturates at 255. It clears only on reset.
- X on sum/carry/mode while in_valid=0 has no effect on state.

Test Plan:
- Reset then idle: hold rst_n=0, then release -> out_valid=0, in_ready=1, level=0, ovf_cnt=0, out_sum=0, out_flags=0.
- Subtract, A=1111 B=0010 (sum=1101, carry=1, mode=1, a_msb=1, b_msb=0) -> next cycle out_sum=1101, flags V0 N1 Z0 C0, level=1.
- Add overflow, A=0111 B=0010 (sum=1001, carry=0, mode=0, a_msb=0, b_msb=0) -> flags V1 N1 Z0 C0, ovf_cnt=1.
- Add vs sub on A=1101 B=1010:
  - add (sum=0111, carry=1) -> flags V1 N0 Z0 C1.
  - sub (sum=0011, carry=1) -> flags V0 N0 Z0 C0.
- Fill to full: push 4 entries with out_ready=0 -> in_ready=0, level=4; a 5th push is ignored. Then assert in_valid and out_ready together -> pop only, level=3. Next cycle the push lands and level stays 3. Order is preserved and pointers wrap.
- Async reset asserted mid-stream with level=3 -> out_valid drops immediately, level=0. The first post-reset push (A=1111 B=0011 sub, sum=1100, carry=1) reads out with flags V0 N1 Z0 C0.
